// File: rtl/td4_io_resp.sv
// I/O responder for the td4 CPU strobe bus: a prescaled down-counter timer
// and a console byte FIFO drained through a valid/ready stream.
module td4_io_resp #(
  parameter logic [7:0]  BASE        = 8'h10,
  parameter int unsigned PRESC       = 50000,
  parameter int unsigned FDEPTH_LOG2 = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [7:0]  ioad,
  input  logic [15:0] iowdt,
  input  logic        ior,
  input  logic        iow,
  output logic [15:0] iordt,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        tmr_flag
);

  localparam int unsigned          CW        = FDEPTH_LOG2 + 1;
  localparam int unsigned          DEPTH     = 2 ** FDEPTH_LOG2;
  localparam logic [CW-1:0]        FULL_CNT  = {1'b1, {FDEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0]        CNT_ONE   = {{FDEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [FDEPTH_LOG2-1:0] PTR_ONE = {{(FDEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [15:0]          PRESC_MAX = 16'(PRESC - 1);

  logic       sel;
  logic [1:0] rsel;
  logic       wr_cnt, wr_ctl, wr_fifo, wr_clr, rd_ctl;

  assign sel     = (ioad[7:2] == BASE[7:2]);
  assign rsel    = ioad[1:0];
  assign wr_cnt  = iow & sel & (rsel == 2'd0);
  assign wr_ctl  = iow & sel & (rsel == 2'd1);
  assign wr_fifo = iow & sel & (rsel == 2'd2);
  assign wr_clr  = iow & sel & (rsel == 2'd3);
  assign rd_ctl  = ior & sel & (rsel == 2'd1);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] presc_q, presc_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        flag_q, flag_d;
  logic        tick, expire;

  // CPU writes override the timer's own update; an expiry always wins over a flag clear.
  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    en_d     = en_q;
    auto_d   = auto_q;
    flag_d   = flag_q;
    tick     = 1'b0;
    expire   = 1'b0;
    if (en_q) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = 16'd0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
    if (tick && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
      if (cnt_q == 16'd1) begin
        expire = 1'b1;
        if (auto_q) cnt_d = reload_q;
        else        en_d  = 1'b0;
      end
    end
    if (wr_cnt) begin
      reload_d = iowdt;
      cnt_d    = iowdt;
      presc_d  = 16'd0;
    end
    if (wr_ctl) begin
      en_d   = iowdt[0];
      auto_d = iowdt[1];
    end
    if (rd_ctl || (wr_ctl && iowdt[2])) flag_d = 1'b0;
    if (expire) flag_d = 1'b1;
  end

  logic [7:0]             mem [0:DEPTH-1];
  logic [FDEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [FDEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CW-1:0]          fcount_q, fcount_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             head_q, head_d;
  logic                   valid_q, valid_d;
  logic                   full, pop, push, last_out;

  assign full     = (fcount_q == FULL_CNT);
  assign pop      = valid_q & con_ready;
  assign push     = wr_fifo & (~full | pop);
  assign last_out = (fcount_q == '0) || ((fcount_q == CNT_ONE) && pop);

  // The head register is refilled from the pushed byte when the FIFO would otherwise be empty.
  always_comb begin
    wptr_d   = push ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d   = pop  ? (rptr_q + PTR_ONE) : rptr_q;
    fcount_d = fcount_q;
    unique case ({push, pop})
      2'b10:   fcount_d = fcount_q + CNT_ONE;
      2'b01:   fcount_d = fcount_q - CNT_ONE;
      default: fcount_d = fcount_q;
    endcase
    ovf_d = ovf_q;
    if (wr_clr) ovf_d = 1'b0;
    else if (wr_fifo && full && !pop) ovf_d = 1'b1;
    valid_d = (fcount_d != '0);
    head_d  = head_q;
    if (fcount_d != '0) begin
      if (last_out) head_d = iowdt[7:0];
      else          head_d = mem[rptr_d];
    end
  end

  logic [15:0] rd_q, rd_d;

  // full is count[FDEPTH_LOG2], so the zero-extended count already carries it.
  always_comb begin
    rd_d = 16'd0;
    if (sel) begin
      unique case (rsel)
        2'd0: rd_d = cnt_q;
        2'd1: rd_d = {13'd0, flag_q, auto_q, en_q};
        2'd2: rd_d = {8'd0, head_q};
        2'd3: rd_d = 16'({ovf_q, fcount_q});
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push) mem[wptr_q] <= iowdt[7:0];
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt_q    <= 16'd0;
      reload_q <= 16'd0;
      presc_q  <= 16'd0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      flag_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fcount_q <= '0;
      ovf_q    <= 1'b0;
      head_q   <= 8'd0;
      valid_q  <= 1'b0;
      rd_q     <= 16'd0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      flag_q   <= flag_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fcount_q <= fcount_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      rd_q     <= rd_d;
    end
  end

  assign iordt     = rd_q;
  assign con_data  = head_q;
  assign con_valid = valid_q;
  assign tmr_flag  = flag_q;

endmodule
